frame_read_sched: RTL and testbench

FRAME_READ_SCHED -- requirements
Module: frame_read_sched

---
 rtl/cam_pkg.sv | 17 +
 rtl/timeout_cnt.sv | 25 ++
 rtl/frame_read_sched.sv | 124 ++++++++++++
 tb/tb_frame_read_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the dual-camera frame read path.
package cam_pkg;

  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int H_ACT_DEF = 1280;
  localparam int V_ACT_DEF = 720;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_READ_CAM1,
    ST_READ_CAM2,
    ST_LINE_END
  } state_t;

endpackage

// File: rtl/timeout_cnt.sv
// Saturating wait-cycle counter; expired is high once LIMIT-1 cycles have been counted.
module timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic rclk,
  input  logic rstn,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(LIMIT - 1));

  // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn)                cnt <= '0;
    else if (clear)           cnt <= '0;
    else if (en && !expired)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/frame_read_sched.sv
// Reads one line from cam1's FIFO then one from cam2's, line by line, for a whole frame.
module frame_read_sched
  import cam_pkg::*;
#(
  parameter int H_ACT   = H_ACT_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic           rclk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic           cam1_ready,
  input  logic           cam2_ready,
  input  logic           sink_ready,
  output logic           cam1_re,
  output logic           cam2_re,
  output logic           cam_id,
  output logic           pix_valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_done,
  output logic           timeout_err,
  output logic           busy
);

  state_t         state;
  logic [X_W-1:0] rd_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           wait_expired;
  logic           rd;
  logic           rd_last;
  logic           y_last;

  // Read enables follow sink_ready within the cycle; abort suppresses them so nothing is popped.
  assign cam1_re     = (state == ST_READ_CAM1) && sink_ready && !abort;
  assign cam2_re     = (state == ST_READ_CAM2) && sink_ready && !abort;
  assign rd          = cam1_re || cam2_re;
  assign rd_last     = (rd_cnt == X_W'(H_ACT - 1));
  assign y_last      = (y_cnt == Y_W'(V_ACT - 1));
  assign line_start  = cam1_re && (rd_cnt == '0);
  assign frame_done  = (state == ST_LINE_END) && y_last && !abort;
  assign timeout_err = (state == ST_WAIT_LINE) && wait_expired && !abort;
  assign busy        = (state != ST_IDLE);

  // Held clear outside WAIT_LINE, so every entry starts counting from zero.
  timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout_cnt (
    .rclk    (rclk),
    .rstn    (rstn),
    .clear   (state != ST_WAIT_LINE),
    .en      (state == ST_WAIT_LINE),
    .expired (wait_expired)
  );

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      rd_cnt    <= '0;
      y_cnt     <= '0;
      pix_valid <= 1'b0;
      cam_id    <= 1'b0;
      x         <= '0;
      y         <= '0;
    end else begin
      // FIFO data appears one cycle after its read enable; tag it with what was read.
      pix_valid <= rd;
      if (rd) begin
        cam_id <= cam2_re;
        x      <= rd_cnt;
        y      <= y_cnt;
      end

      if (abort) begin
        state  <= ST_IDLE;
        rd_cnt <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              state  <= ST_WAIT_LINE;
              rd_cnt <= '0;
              y_cnt  <= '0;
            end
          end
          ST_WAIT_LINE: begin
            if (wait_expired)                  state <= ST_IDLE;
            else if (cam1_ready && cam2_ready) state <= ST_READ_CAM1;
          end
          ST_READ_CAM1: begin
            if (cam1_re) begin
              if (rd_last) begin
                rd_cnt <= '0;
                state  <= ST_READ_CAM2;
              end else begin
                rd_cnt <= rd_cnt + X_W'(1);
              end
            end
          end
          ST_READ_CAM2: begin
            if (cam2_re) begin
              if (rd_last) begin
                rd_cnt <= '0;
                state  <= ST_LINE_END;
              end else begin
                rd_cnt <= rd_cnt + X_W'(1);
              end
            end
          end
          ST_LINE_END: begin
            if (y_last) begin
              state <= ST_IDLE;
            end else begin
              y_cnt <= y_cnt + Y_W'(1);
              state <= ST_WAIT_LINE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_read_sched.sv
// Scoreboard bench for frame_read_sched with a 4x2 frame and a 16-cycle line timeout.
module tb_frame_read_sched;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int TO = 16;
  // Each line costs one WAIT_LINE cycle, 2*H read cycles and one LINE_END cycle.
  localparam int FD_CYCLE = V * (2 * H + 2);

  typedef struct packed {
    logic        cam;
    logic [10:0] px;
    logic [9:0]  py;
  } pix_t;

  logic        rclk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cam1_ready = 1'b0;
  logic        cam2_ready = 1'b0;
  logic        sink_ready = 1'b0;
  logic        cam1_re, cam2_re, cam_id, pix_valid;
  logic [10:0] x;
  logic [9:0]  y;
  logic        line_start, frame_done, timeout_err, busy;

  int   checks = 0;
  int   errors = 0;
  int   cnt_re1 = 0, cnt_re2 = 0, cnt_pix = 0, cnt_fd = 0, cnt_to = 0, cnt_ls = 0;
  pix_t exp_q[$];

  frame_read_sched #(.H_ACT(H), .V_ACT(V), .TIMEOUT(TO)) dut (
    .rclk        (rclk),
    .rstn        (rstn),
    .start       (start),
    .abort       (abort),
    .cam1_ready  (cam1_ready),
    .cam2_ready  (cam2_ready),
    .sink_ready  (sink_ready),
    .cam1_re     (cam1_re),
    .cam2_re     (cam2_re),
    .cam_id      (cam_id),
    .pix_valid   (pix_valid),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: event counting, read-enable rules and scoreboard pops, all at the falling edge.
  always @(negedge rclk) begin
    if (rstn) begin
      if (cam1_re)     cnt_re1++;
      if (cam2_re)     cnt_re2++;
      if (frame_done)  cnt_fd++;
      if (timeout_err) cnt_to++;
      if (line_start)  cnt_ls++;
      if (cam1_re || cam2_re) begin
        checks++;
        if (!sink_ready || (cam1_re && cam2_re)) begin
          errors++;
          $display("FAIL re_rule: cam1_re=%0b cam2_re=%0b sink_ready=%0b", cam1_re, cam2_re, sink_ready);
        end
      end
      if (pix_valid) begin
        pix_t got;
        got = '{cam: cam_id, px: x, py: y};
        cnt_pix++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_unexpected: got cam=%0d x=%0d y=%0d, none expected", got.cam, got.px, got.py);
        end else begin
          pix_t want;
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL pixel: got cam=%0d x=%0d y=%0d, want cam=%0d x=%0d y=%0d",
                     got.cam, got.px, got.py, want.cam, want.px, want.py);
          end
        end
      end
    end
  end

  task automatic clear_counts();
    cnt_re1 = 0; cnt_re2 = 0; cnt_pix = 0; cnt_fd = 0; cnt_to = 0; cnt_ls = 0;
  endtask

  task automatic push_pixels(input int lines, input int cam2_count);
    for (int ly = 0; ly < lines; ly++) begin
      for (int lx = 0; lx < H; lx++) exp_q.push_back('{cam: 1'b0, px: 11'(lx), py: 10'(ly)});
      for (int lx = 0; lx < cam2_count; lx++) exp_q.push_back('{cam: 1'b1, px: 11'(lx), py: 10'(ly)});
    end
  endtask

  // Start is sampled at the next rising edge; returns just after it, inside the first WAIT_LINE cycle.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge rclk); #2;
    start = 1'b0;
  endtask

  // Returns the index of the falling edge (1 = first after the call) where frame_done is seen, 0 if never.
  task automatic wait_frame_done(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge rclk);
      if (frame_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic settle_and_check_queue(input string tag);
    repeat (3) @(negedge rclk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_queue: %0d pixels still expected, want 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(posedge rclk); #2;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; cam1_ready = 1'b1; cam2_ready = 1'b1; sink_ready = 1'b1;
    repeat (3) @(negedge rclk);
    checks++;
    if ({cam1_re, cam2_re, cam_id, pix_valid, x, y, line_start, frame_done, timeout_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: re=%0b%0b pv=%0b x=%0d y=%0d busy=%0b, want all 0",
               cam1_re, cam2_re, pix_valid, x, y, busy);
    end
    @(posedge rclk); #2;
    start = 1'b0;
    rstn = 1'b1;
    @(negedge rclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %0b want 0", busy);
    end
    @(posedge rclk); #2;
  endtask

  task automatic run_frame(input string tag);
    int n;
    clear_counts();
    cam1_ready = 1'b1; cam2_ready = 1'b1; sink_ready = 1'b1;
    push_pixels(V, H);
    pulse_start();
    wait_frame_done(FD_CYCLE + 10, n);
    checks++;
    if (n !== FD_CYCLE) begin
      errors++;
      $display("FAIL %s_frame_done_cycle: got %0d want %0d", tag, n, FD_CYCLE);
    end
    @(negedge rclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after_frame: busy=%0b want 0", tag, busy);
    end
    settle_and_check_queue(tag);
    checks++;
    if (cnt_re1 !== V * H || cnt_re2 !== V * H || cnt_ls !== V || cnt_fd !== 1) begin
      errors++;
      $display("FAIL %s_counts: re1=%0d re2=%0d ls=%0d fd=%0d want %0d %0d %0d 1",
               tag, cnt_re1, cnt_re2, cnt_ls, cnt_fd, V * H, V * H, V);
    end
  endtask

  task automatic test_full_frame();
    run_frame("full");
  endtask

  task automatic test_sink_stall();
    clear_counts();
    cam1_ready = 1'b1; cam2_ready = 1'b1; sink_ready = 1'b1;
    push_pixels(V, H);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(posedge rclk); #2;
      sink_ready = ~sink_ready;
      if (!busy) break;
    end
    sink_ready = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_finish: busy=%0b want 0 within budget", busy);
    end
    settle_and_check_queue("stall");
    checks++;
    if (cnt_re1 !== V * H || cnt_pix !== 2 * V * H || cnt_fd !== 1) begin
      errors++;
      $display("FAIL stall_counts: re1=%0d pix=%0d fd=%0d want %0d %0d 1",
               cnt_re1, cnt_pix, cnt_fd, V * H, 2 * V * H);
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_counts();
    cam1_ready = 1'b1; cam2_ready = 1'b0; sink_ready = 1'b1;
    pulse_start();
    n = 0;
    for (int i = 1; i <= TO + 8; i++) begin
      @(negedge rclk);
      if (timeout_err) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d want %0d", n, TO);
    end
    @(negedge rclk);
    checks++;
    if (busy !== 1'b0 || cnt_re1 + cnt_re2 !== 0 || cnt_to !== 1) begin
      errors++;
      $display("FAIL timeout_after: busy=%0b reads=%0d to=%0d want 0 0 1", busy, cnt_re1 + cnt_re2, cnt_to);
    end
    cam2_ready = 1'b1;
    @(posedge rclk); #2;
  endtask

  task automatic test_abort();
    clear_counts();
    cam1_ready = 1'b1; cam2_ready = 1'b1; sink_ready = 1'b1;
    push_pixels(1, 1);
    pulse_start();
    // Cycle 7 after the start cycle holds the second cam2 read of line 0.
    repeat (6) @(posedge rclk);
    #2;
    abort = 1'b1;
    @(negedge rclk);
    checks++;
    if (cam2_re !== 1'b0 || cam1_re !== 1'b0) begin
      errors++;
      $display("FAIL abort_re: cam1_re=%0b cam2_re=%0b want 0 0", cam1_re, cam2_re);
    end
    @(posedge rclk); #2;
    abort = 1'b0;
    @(negedge rclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%0b want 0", busy);
    end
    settle_and_check_queue("abort");
    checks++;
    if (cnt_fd !== 0 || cnt_re2 !== 1) begin
      errors++;
      $display("FAIL abort_counts: fd=%0d re2=%0d want 0 1", cnt_fd, cnt_re2);
    end
    run_frame("after_abort");
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    @(posedge rclk); #2;
    start = 1'b0; abort = 1'b0;
    @(negedge rclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%0b want 0", busy);
    end
    @(posedge rclk); #2;
  endtask

  task automatic test_start_ignored_and_reset();
    int n;
    clear_counts();
    cam1_ready = 1'b1; cam2_ready = 1'b1; sink_ready = 1'b1;
    push_pixels(V, H);
    pulse_start();
    repeat (6) @(posedge rclk);
    #2;
    start = 1'b1;
    @(posedge rclk); #2;
    start = 1'b0;
    wait_frame_done(FD_CYCLE, n);
    checks++;
    if (n + 7 !== FD_CYCLE) begin
      errors++;
      $display("FAIL start_ignored_frame_done: got cycle %0d want %0d", n + 7, FD_CYCLE);
    end
    settle_and_check_queue("start_ignored");
    checks++;
    if (cnt_fd !== 1 || cnt_re1 !== V * H) begin
      errors++;
      $display("FAIL start_ignored_counts: fd=%0d re1=%0d want 1 %0d", cnt_fd, cnt_re1, V * H);
    end

    // Reset in the middle of line 0's cam1 reads; only the first pixel surfaces beforehand.
    exp_q.push_back('{cam: 1'b0, px: 11'd0, py: 10'd0});
    pulse_start();
    repeat (3) @(posedge rclk);
    #2;
    rstn = 1'b0;
    @(negedge rclk);
    checks++;
    if ({cam1_re, cam2_re, cam_id, pix_valid, x, y, line_start, frame_done, timeout_err, busy} !== '0) begin
      errors++;
      $display("FAIL midline_reset_outputs: re=%0b%0b pv=%0b x=%0d y=%0d busy=%0b, want all 0",
               cam1_re, cam2_re, pix_valid, x, y, busy);
    end
    @(posedge rclk); #2;
    clear_counts();
    rstn = 1'b1;
    repeat (6) @(negedge rclk);
    checks++;
    if (busy !== 1'b0 || cnt_re1 + cnt_re2 !== 0 || cnt_pix !== 0) begin
      errors++;
      $display("FAIL midline_reset_resume: busy=%0b reads=%0d pix=%0d want 0 0 0",
               busy, cnt_re1 + cnt_re2, cnt_pix);
    end
    settle_and_check_queue("midline_reset");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sink_stall();
    test_timeout();
    test_abort();
    test_start_abort_idle();
    test_start_ignored_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
